// File: rtl/snoop_responder.sv
// snoop_responder
//   Per-processor snoop responder. Holds a direct-mapped MSI state/tag/data
//   table for the owning processor and answers snoops from the other
//   processors. On a hit it can supply the line on bus_word for HOLD cycles,
//   then downgrades (read miss) or invalidates (write miss / invalidate) it.
//
// Ports
//   clk, reset                : clock (rising edge), async active-high reset
//   snoop_valid/ready         : snoop request handshake (ready only in IDLE)
//   snoop_src/op/addr         : requesting processor, opcode, line address
//   fill_valid/ready          : local install/update of a line (ready in IDLE)
//   fill_addr/state/data      : line address, MSI state (11 -> I), line data
//   bus_word                  : {0, supply, state-before-snoop, data}, zero
//                               except while driving
//   snoop_done                : one-cycle pulse when a snoop completes
module snoop_responder #(
  parameter logic [1:0] PROC_ID = 2'd0,
  parameter int         LINES   = 4,
  parameter int         HOLD    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        snoop_valid,
  output logic        snoop_ready,
  input  logic [1:0]  snoop_src,
  input  logic [1:0]  snoop_op,
  input  logic [7:0]  snoop_addr,
  input  logic        fill_valid,
  output logic        fill_ready,
  input  logic [7:0]  fill_addr,
  input  logic [1:0]  fill_state,
  input  logic [7:0]  fill_data,
  output logic [11:0] bus_word,
  output logic        snoop_done
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 8 - IDX_W;
  localparam int CNT_W = $clog2(HOLD + 1);

  localparam logic [1:0] ST_I  = 2'b00;
  localparam logic [1:0] ST_S  = 2'b01;
  localparam logic [1:0] ST_M  = 2'b10;
  localparam logic [1:0] OP_RD = 2'b01;
  localparam logic [1:0] OP_WR = 2'b10;

  typedef enum logic [1:0] {IDLE, LOOKUP, DRIVE, UPDATE} fsm_t;

  fsm_t state_q, state_d;

  logic [1:0]       tbl_state [LINES];
  logic [TAG_W-1:0] tbl_tag   [LINES];
  logic [7:0]       tbl_data  [LINES];

  logic [7:0]       addr_p1;
  logic [1:0]       op_p1;
  logic [CNT_W-1:0] cnt_p1;

  logic             accept;
  logic             hit;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       ent_state;
  logic [IDX_W-1:0] fill_idx;

  // Encoding 11 is not a legal MSI state; install it as invalid.
  function automatic logic [1:0] fill_norm(input logic [1:0] s);
    return (s == 2'b11) ? ST_I : s;
  endfunction

  // State left behind by a hitting snoop: a hit is always S or M, so a read
  // miss always ends in S and everything else invalidates.
  function automatic logic [1:0] snoop_next(input logic [1:0] op);
    return (op == OP_RD) ? ST_S : ST_I;
  endfunction

  // Uses state_q directly so accept does not loop through the output logic.
  assign accept = snoop_valid && (state_q == IDLE) &&
                  (snoop_op != 2'b00) && (snoop_src != PROC_ID);

  assign idx       = addr_p1[IDX_W-1:0];
  assign tag       = addr_p1[7:IDX_W];
  assign ent_state = tbl_state[idx];
  assign hit       = ((ent_state == ST_S) || (ent_state == ST_M)) &&
                     (tbl_tag[idx] == tag);
  assign fill_idx  = fill_addr[IDX_W-1:0];

  // Capture stage: request registers, hold counter and the line table.
  // Fills and snoop updates never collide: fills only land in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_p1 <= '0;
      op_p1   <= '0;
      cnt_p1  <= '0;
      for (int i = 0; i < LINES; i++) begin
        tbl_state[i] <= ST_I;
        tbl_tag[i]   <= '0;
        tbl_data[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_p1 <= snoop_addr;
        op_p1   <= snoop_op;
      end
      if (state_q == LOOKUP) begin
        cnt_p1 <= CNT_W'(HOLD);
      end else if (state_q == DRIVE) begin
        cnt_p1 <= cnt_p1 - CNT_W'(1);
      end
      if ((state_q == IDLE) && fill_valid) begin
        tbl_state[fill_idx] <= fill_norm(fill_state);
        tbl_tag[fill_idx]   <= fill_addr[7:IDX_W];
        tbl_data[fill_idx]  <= fill_data;
      end
      if (state_q == UPDATE) begin
        tbl_state[idx] <= snoop_next(op_p1);
      end
    end
  end

  // Output stage: outputs depend only on registered state, so an async
  // reset clears bus_word immediately.
  always_comb begin
    state_d     = state_q;
    snoop_ready = 1'b0;
    fill_ready  = 1'b0;
    bus_word    = '0;
    snoop_done  = 1'b0;
    case (state_q)
      IDLE: begin
        snoop_ready = 1'b1;
        fill_ready  = 1'b1;
        if (accept) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          if ((op_p1 == OP_RD) || ((op_p1 == OP_WR) && (ent_state == ST_M)))
            state_d = DRIVE;
          else
            state_d = UPDATE;
        end else begin
          snoop_done = 1'b1;
          state_d    = IDLE;
        end
      end
      DRIVE: begin
        bus_word = {2'b01, ent_state, tbl_data[idx]};
        if (cnt_p1 == CNT_W'(1)) state_d = UPDATE;
      end
      UPDATE: begin
        snoop_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
